sram_controller: RTL and testbench
==================================

# sram_controller

Memory-side responder for the ARM pipeline's MEM stage. Accepts one 32-bit word read or write request from the core and performs it as two 16-bit accesses to the external SRAM, each with a programmable wait count. While the access is in progress, `ready` stays low so the core freezes its pipeline. Sits between `mem_stage` (initiator) and the board SRAM pins.

## Interface
- `WAIT_CYCLES`, default 2: cycles per 16-bit SRAM phase. Legal range is ≥1.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `clk  in  1`: single clock; all logic on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `mem_r_en  in  1`: read request. Held stable by the core until `ready`.
- `mem_w_en  in  1`: write request. Held stable by the core until `ready`.
- `address  in  32`: byte address, word aligned. Bits [1:0] are ignored.
- `wdata  in  32`: write data. Stable while `mem_w_en` is high.
- `rdata  out  32`: read data. Registered; valid in the cycle `ready` goes high after a read.
- `ready  out  1`: high = no access pending. The core must freeze when this is low.
- `sram_addr  out  18`: SRAM halfword address.
- `sram_dq_out  out  16`: data driven to SRAM.
- `sram_dq_oe  out  1`: tri-state enable for `sram_dq_out`. The tri-state buffer itself lives at the top level.
- `sram_dq_in  in  16`: data returned by SRAM.
- `sram_we_n  out  1`: active-low write enable.

## Operation
- Address mapping:
  - `idx = (address - BASE_ADDR) >> 2`, truncated to 17 bits.
  - Low phase uses `sram_addr = {idx,0}` and carries bits [15:0].
  - High phase uses `{idx,1}` and carries bits [31:16].
- FSM states: IDLE, LO, HI, DONE. A down-counter `cnt` (width clog2(WAIT_CYCLES+1)) times each phase.
- IDLE:
  - If `mem_w_en | mem_r_en`: go to LO and load `cnt = WAIT_CYCLES-1`. Latch `op_write = mem_w_en`; write wins if both are high.
  - Otherwise remain in IDLE.
- LO:
  - Drives `sram_addr = {idx,0}`.
  - Write: `sram_dq_out = wdata[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - Read: `sram_we_n = 1`, `oe = 0`.
  - Decrements `cnt`. When `cnt == 0`: for a read, capture `sram_dq_in` into `rdata[15:0]`; then go to HI and reload `cnt`.
- HI: same as LO using `{idx,1}` and bits [31:16]. When `cnt == 0`, go to DONE.
- DONE: SRAM is idle (`we_n = 1`, `oe = 0`). Unconditionally go to IDLE next cycle.
- `ready = (state==IDLE & ~mem_r_en & ~mem_w_en) | state==DONE`. This is combinational from the state and request inputs.
- `sram_addr`, `sram_dq_out`, `sram_dq_oe` and `sram_we_n` are registered outputs, so phase values appear from the first cycle of each phase.
- `rdata` holds its value until the next read completes. Writes do not modify it.

## Timing
- Request first seen in IDLE at cycle 0. LO occupies cycles 1..W, HI occupies W+1..2W, and DONE is cycle 2W+1, where `ready` = 1.
- The core advances on the edge that ends DONE. A back-to-back request seen in the following IDLE cycle starts immediately, so throughput is one word per 2W+2 cycles.
- No request: `ready` is 1 every cycle and the SRAM outputs stay idle.
- Reset values:
  - state IDLE, `cnt` 0, `rdata` 0.
  - `sram_addr` 0, `sram_dq_out` 0, `sram_dq_oe` 0, `sram_we_n` 1.
  - `ready` follows the IDLE rule.
- Reset mid-access: the access is abandoned and the block is in IDLE the next cycle. A half-written word stays partially written, which is a documented limitation. If the request is still asserted after reset, the access restarts from LO.
- Request inputs changing before `ready` is a core protocol violation and the behaviour is undefined. Latched `idx`, `wdata` and `op_write` are sampled only in IDLE.

## Structure
- Shared package `arm_mem_pkg` holds:
  - state enum `sram_state_t`;
  - `SRAM_ADDR_W = 18`, `SRAM_DATA_W = 16`;
  - default `BASE_ADDR = 1024`.
- One sub-module, `sram_wait_counter`: loadable down-counter with a `zero` flag. It is parameterized by `WAIT_CYCLES` and reused by the cache work that follows.
- FSM, address/data muxing and `rdata` capture stay in `sram_controller`.

## Test plan
- Idle: with W=2, no requests for 10 cycles → `ready` = 1, `sram_we_n` = 1 and `oe` = 0 throughout.
- Write: W=2, write 0xDEADBEEF to 1024 → `ready` low for cycles 0–4 and high at cycle 5; SRAM[0] = 0xBEEF, SRAM[1] = 0xDEAD.
- Read-back: W=2, read from 1024 after the write → `rdata` = 0xDEADBEEF with `ready` = 1 at cycle 5. Read from 1028 → `sram_addr` = 2 then 3.
- Back-to-back: W=1, write 0x12345678 to 1032 followed immediately by a read of 1032 → each access completes in 4 cycles and the read returns 0x12345678.
- Simultaneous read and write: `mem_r_en = mem_w_en = 1`, `wdata` = 0xA5A55A5A at 1036 → a write is performed and `rdata` is unchanged.
- Reset mid-write: assert `rst` during HI of a write to 1040 → next cycle is IDLE with `we_n` = 1 and `oe` = 0. With the request still held after reset, the access reruns and completes 2W+2 cycles after release.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared types and constants for the MEM-stage SRAM path
package arm_mem_pkg;
    typedef enum logic [1:0] {IDLE, LO, HI, DONE} sram_state_t;
    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;
    localparam int DEFAULT_BASE_ADDR = 1024;
endpackage

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter that times one SRAM phase
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 2,
    localparam int CW = $clog2(WAIT_CYCLES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    output logic          zero,
    output logic [CW-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= CW'(WAIT_CYCLES - 1);
        else if (dec && !zero) cnt <= cnt - 1'b1;
    end
    assign zero = cnt == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit core access split into two timed 16-bit SRAM phases
module sram_controller import arm_mem_pkg::*; #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    localparam int CW = $clog2(WAIT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_r_en,
    input  logic                   mem_w_en,
    input  logic [31:0]            address,
    input  logic [31:0]            wdata,
    output logic [31:0]            rdata,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    output logic                   sram_dq_oe,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_we_n
);
    sram_state_t state;
    logic req, load, dec, zero, op_write;
    logic [16:0] idx_in, idx_q;
    logic [15:0] wdata_hi, rd_lo;
    logic [CW-1:0] cnt;
    assign req    = mem_r_en | mem_w_en;
    assign idx_in = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign ready  = (state == IDLE && !req) || state == DONE;
    assign load   = (state == IDLE && req) || (state == LO && zero);
    assign dec    = state == LO || state == HI;
    sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_cnt (
        .clk (clk),
        .rst (rst),
        .load(load),
        .dec (dec),
        .zero(zero),
        .cnt (cnt)
    );
    // Pins are registered from the next-state decision so each phase is valid from its first cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rdata       <= '0;
            rd_lo       <= '0;
            idx_q       <= '0;
            wdata_hi    <= '0;
            op_write    <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state      <= LO;
                    op_write   <= mem_w_en;
                    idx_q      <= idx_in;
                    wdata_hi   <= wdata[31:16];
                    sram_addr  <= {idx_in, 1'b0};
                    sram_dq_oe <= mem_w_en;
                    sram_we_n  <= !mem_w_en;
                    if (mem_w_en) sram_dq_out <= wdata[15:0];
                end
                LO: if (zero) begin
                    state     <= HI;
                    sram_addr <= {idx_q, 1'b1};
                    if (op_write) sram_dq_out <= wdata_hi;
                    else rd_lo <= sram_dq_in;
                end
                HI: if (zero) begin
                    state      <= DONE;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                    if (!op_write) rdata <= {sram_dq_in, rd_lo};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: scoreboard bench driving a W=2 and a W=1 controller against SRAM models
module tb_sram_controller;
    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst     [2];
    logic        r_en    [2];
    logic        w_en    [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic        ready   [2];
    logic [17:0] sram_addr [2];
    logic [15:0] dq_out  [2];
    logic [15:0] dq_in   [2];
    logic        oe      [2];
    logic        we_n    [2];
    logic [15:0] mem     [2][64];
    exp_t q0[$], q1[$];
    int lat [2];
    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst[0]), .mem_r_en(r_en[0]), .mem_w_en(w_en[0]),
        .address(addr[0]), .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]),
        .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]), .sram_dq_oe(oe[0]),
        .sram_dq_in(dq_in[0]), .sram_we_n(we_n[0])
    );
    sram_controller #(.WAIT_CYCLES(1)) u_w1 (
        .clk(clk), .rst(rst[1]), .mem_r_en(r_en[1]), .mem_w_en(w_en[1]),
        .address(addr[1]), .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]),
        .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]), .sram_dq_oe(oe[1]),
        .sram_dq_in(dq_in[1]), .sram_we_n(we_n[1])
    );

    always @(posedge clk)
        for (int d = 0; d < 2; d++)
            if (!we_n[d] && oe[d]) mem[d][sram_addr[d][5:0]] <= dq_out[d];
    assign dq_in[0] = mem[0][sram_addr[0][5:0]];
    assign dq_in[1] = mem[1][sram_addr[1][5:0]];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(int d, logic [31:0] data, int l);
        exp_t e;
        e.data = data;
        e.lat  = l;
        if (d == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor: counts cycles of each held request and scores the response when ready rises
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (r_en[d] || w_en[d]) begin
                lat[d]++;
                if (ready[d]) begin
                    exp_t e;
                    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_empty: unexpected response on dut %0d", d);
                    end else begin
                        if (d == 0) e = q0.pop_front();
                        else e = q1.pop_front();
                        check("rdata", rdata[d], e.data);
                        check("latency", 32'(lat[d]), 32'(e.lat));
                    end
                    lat[d] = 0;
                end
            end
        end
    end

    task automatic access(int d, bit rd, bit wr, logic [31:0] a, logic [31:0] wd, logic [31:0] exp_rd);
        int w = (d == 0) ? 2 : 1;
        logic [16:0] idx = 17'((a - 32'd1024) >> 2);
        bit got = 0;
        push(d, exp_rd, 2 * w + 2);
        r_en[d]  = rd;
        w_en[d]  = wr;
        addr[d]  = a;
        wdata[d] = wd;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            if (k == 1) check("lo_addr", 32'(sram_addr[d]), 32'({idx, 1'b0}));
            if (k == w + 1) begin
                check("hi_addr", 32'(sram_addr[d]), 32'({idx, 1'b1}));
                check("hi_we_n", 32'(we_n[d]), 32'(!wr));
            end
            got = ready[d];
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: dut %0d never raised ready", d);
        end
        @(posedge clk);
        #1;
        r_en[d] = 1'b0;
        w_en[d] = 1'b0;
    endtask

    initial begin
        bit got;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; r_en[d] = 1'b0; w_en[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
        end
        @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", 32'(ready[d]), 32'd1);
            check("rst_we_n", 32'(we_n[d]), 32'd1);
            check("rst_oe", 32'(oe[d]), 32'd0);
            check("rst_addr", 32'(sram_addr[d]), 32'd0);
            check("rst_dq", 32'(dq_out[d]), 32'd0);
            check("rst_rdata", rdata[d], 32'd0);
        end
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("idle_ready", 32'(ready[0]), 32'd1);
            check("idle_we_n", 32'(we_n[0]), 32'd1);
            check("idle_oe", 32'(oe[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        access(0, 0, 1, 32'd1024, 32'hDEADBEEF, 32'h0);
        check("mem0_lo", 32'(mem[0][0]), 32'h0000BEEF);
        check("mem0_hi", 32'(mem[0][1]), 32'h0000DEAD);
        access(0, 1, 0, 32'd1024, 32'h0, 32'hDEADBEEF);
        access(0, 0, 1, 32'd1028, 32'hCAFEF00D, 32'hDEADBEEF);
        access(0, 1, 0, 32'd1028, 32'h0, 32'hCAFEF00D);
        access(1, 0, 1, 32'd1032, 32'h12345678, 32'h0);
        access(1, 1, 0, 32'd1032, 32'h0, 32'h12345678);
        check("b2b_mem_lo", 32'(mem[1][4]), 32'h00005678);
        check("b2b_mem_hi", 32'(mem[1][5]), 32'h00001234);
        access(0, 1, 1, 32'd1036, 32'hA5A55A5A, 32'hCAFEF00D);
        check("rw_mem_lo", 32'(mem[0][6]), 32'h00005A5A);
        check("rw_mem_hi", 32'(mem[0][7]), 32'h0000A5A5);
        // Reset lands in HI (cycle 3); held request reruns from cycle 4 and ends in DONE at cycle 9
        push(0, 32'h0, 10);
        w_en[0]  = 1'b1;
        addr[0]  = 32'd1040;
        wdata[0] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b1;
        @(posedge clk);
        #1;
        rst[0] = 1'b0;
        @(negedge clk);
        check("rst_mid_we_n", 32'(we_n[0]), 32'd1);
        check("rst_mid_oe", 32'(oe[0]), 32'd0);
        check("rst_mid_ready", 32'(ready[0]), 32'd0);
        got = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = ready[0];
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL timeout: rerun after reset never completed");
        end
        @(posedge clk);
        #1;
        w_en[0] = 1'b0;
        check("rerun_mem_lo", 32'(mem[0][8]), 32'h0000F00D);
        check("rerun_mem_hi", 32'(mem[0][9]), 32'h00000BAD);
        access(0, 1, 0, 32'd1040, 32'h0, 32'h0BADF00D);
        repeat (2) @(posedge clk);
        check("sb_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
